// File: rtl/dbg_console_pkg.sv
// Shared constants and request decoding for the MMIO debug console.
package dbg_console_pkg;

    localparam logic [19:0] DBG_PRINTF_TAG   = 20'h01010;
    localparam logic [63:0] DBG_EXIT_SUCCESS = 64'h1;
    localparam logic [7:0]  DBG_NO_INPUT     = 8'h00;

    typedef enum logic [1:0] {
        ReqRead,
        ReqChar,
        ReqExit,
        ReqOther
    } req_kind_e;

    // A printf tag takes precedence over the exit flag in bit 0.
    function automatic req_kind_e decode_req(input logic wen, input logic [63:0] wdata);
        if (!wen) begin
            return ReqRead;
        end
        if (wdata[63:44] == DBG_PRINTF_TAG) begin
            return ReqChar;
        end
        if (wdata[0]) begin
            return ReqExit;
        end
        return ReqOther;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head is read combinationally from storage.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign dout = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= din;
                wr_ptr_q                <= wr_ptr_q + (AW + 1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/dbg_console.sv
// Debug console responder: printf bytes to a TX stream, host bytes back on reads,
// and a sticky exit flag/result for the top level.
module dbg_console
    import dbg_console_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TX_DEPTH   = 16,
    parameter int unsigned RX_DEPTH   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid,
    output logic                    ready,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic                    wen,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wmask,
    output logic                    rvalid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    tx_valid,
    output logic [7:0]              tx_data,
    input  logic                    tx_ready,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    output logic                    rx_overflow,
    output logic                    done,
    output logic                    success,
    output logic [DATA_WIDTH-1:0]   exit_word
);

    logic                  tx_full, tx_empty, rx_full, rx_empty;
    logic [7:0]            tx_head, rx_head;
    req_kind_e             req_kind;
    logic                  accept, is_read, tx_push, tx_pop, rx_pop, exit_hit;
    logic                  rvalid_q, overflow_q, done_q, success_q;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d, exit_word_q;

    // The whole region is one register, so address and byte mask carry no meaning.
    logic unused_ok;
    assign unused_ok = ^{addr, wmask};

    assign req_kind = decode_req(wen, wdata);
    assign ready    = !tx_full;
    assign accept   = valid && ready;
    assign is_read  = accept && (req_kind == ReqRead);
    assign tx_push  = accept && (req_kind == ReqChar);
    assign tx_pop   = !tx_empty && tx_ready;
    assign rx_pop   = is_read && !rx_empty;
    assign exit_hit = accept && (req_kind == ReqExit) && !done_q;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (wdata[7:0]),
        .dout  (tx_head),
        .empty (tx_empty),
        .full  (tx_full)
    );

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid),
        .pop   (rx_pop),
        .din   (rx_data),
        .dout  (rx_head),
        .empty (rx_empty),
        .full  (rx_full)
    );

    // Read data is held between responses; writes leave it untouched.
    always_comb begin
        rdata_d = rdata_q;
        if (is_read) begin
            rdata_d = {{(DATA_WIDTH - 8){1'b0}}, (rx_empty ? DBG_NO_INPUT : rx_head)};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
            success_q   <= 1'b0;
            exit_word_q <= '0;
        end else begin
            rvalid_q <= accept;
            rdata_q  <= rdata_d;
            if (rx_valid && rx_full && !rx_pop) begin
                overflow_q <= 1'b1;
            end
            if (exit_hit) begin
                done_q      <= 1'b1;
                exit_word_q <= wdata;
                success_q   <= (wdata == DATA_WIDTH'(DBG_EXIT_SUCCESS));
            end
        end
    end

    assign rvalid      = rvalid_q;
    assign rdata       = rdata_q;
    assign tx_valid    = !tx_empty;
    assign tx_data     = tx_head;
    assign rx_overflow = overflow_q;
    assign done        = done_q;
    assign success     = success_q;
    assign exit_word   = exit_word_q;

endmodule

// File: tb/tb_dbg_console.sv
// Self-checking bench for dbg_console against a queue-based model of the console.
module tb_dbg_console;

    localparam int unsigned TX_DEPTH = 16;
    localparam int unsigned RX_DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, ready, wen, rvalid;
    logic [31:0] addr;
    logic [63:0] wdata, rdata, exit_word;
    logic [7:0]  wmask, tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_overflow, done, success;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic        m_done, m_success, m_ovf, m_rvalid, m_rd_resp;
    logic [63:0] m_exit, m_rdata;

    always #5 clk = ~clk;

    dbg_console u_dut (
        .clk         (clk),
        .rst         (rst),
        .valid       (valid),
        .ready       (ready),
        .addr        (addr),
        .wen         (wen),
        .wdata       (wdata),
        .wmask       (wmask),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_overflow (rx_overflow),
        .done        (done),
        .success     (success),
        .exit_word   (exit_word)
    );

    function automatic logic [63:0] char_word(input logic [7:0] b);
        logic [63:0] r;
        r = {$urandom, $urandom};
        return {20'h01010, r[35:0], b};
    endfunction

    function automatic logic [63:0] plain_word(input logic bit0);
        logic [63:0] r;
        r = {$urandom, $urandom};
        r[0] = bit0;
        if (r[63:44] == 20'h01010) r[63] = ~r[63];
        return r;
    endfunction

    task automatic idle();
        valid   = 1'b0;
        wen     = 1'b0;
        wdata   = '0;
        addr    = $urandom;
        wmask   = 8'($urandom);
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    task automatic model_clear();
        tx_q.delete();
        rx_q.delete();
        m_done = 0; m_success = 0; m_ovf = 0; m_rvalid = 0; m_rd_resp = 0;
        m_exit = '0; m_rdata = '0;
    endtask

    // One clock: the model consumes the inputs seen at the rising edge.
    task automatic tick();
        logic acc;
        @(posedge clk);
        if (rst) begin
            acc = valid && (tx_q.size() < TX_DEPTH);
            if (tx_ready && tx_q.size() > 0) void'(tx_q.pop_front());
            m_rvalid  = acc;
            m_rd_resp = 0;
            if (acc) begin
                if (!wen) begin
                    m_rd_resp = 1;
                    if (rx_q.size() > 0) m_rdata = {56'b0, rx_q.pop_front()};
                    else m_rdata = '0;
                end else if (wdata[63:44] == 20'h01010) begin
                    tx_q.push_back(wdata[7:0]);
                end else if (wdata[0] && !m_done) begin
                    m_done = 1; m_exit = wdata; m_success = (wdata == 64'd1);
                end
            end
            if (rx_valid) begin
                if (rx_q.size() < RX_DEPTH) rx_q.push_back(rx_data);
                else m_ovf = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        tx_ready = 1'b0;
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            checks += 9;
            if (rvalid !== 1'b0)       begin errors++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
            if (rdata !== 64'd0)       begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
            if (tx_valid !== 1'b0)     begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
            if (tx_data !== 8'd0)      begin errors++; $display("FAIL reset_tx_data: got %h want 0", tx_data); end
            if (rx_overflow !== 1'b0)  begin errors++; $display("FAIL reset_rx_overflow: got %b want 0", rx_overflow); end
            if (done !== 1'b0)         begin errors++; $display("FAIL reset_done: got %b want 0", done); end
            if (success !== 1'b0)      begin errors++; $display("FAIL reset_success: got %b want 0", success); end
            if (exit_word !== 64'd0)   begin errors++; $display("FAIL reset_exit_word: got %h want 0", exit_word); end
            if (ready !== 1'b1)        begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
            @(negedge clk);
        end
    endtask

    task automatic test_char_write();
        tx_ready = 1'b1;
        valid = 1'b1; wen = 1'b1; wdata = 64'h0101_0000_0000_0041;
        tick();
        idle();
        checks += 3;
        if (rvalid !== 1'b1)    begin errors++; $display("FAIL char_rvalid: got %b want 1", rvalid); end
        if (tx_valid !== 1'b1)  begin errors++; $display("FAIL char_tx_valid: got %b want 1", tx_valid); end
        if (tx_data !== 8'h41)  begin errors++; $display("FAIL char_tx_data: got %h want 41", tx_data); end
        tick();
        checks += 2;
        if (tx_valid !== 1'b0)  begin errors++; $display("FAIL char_drained: got %b want 0", tx_valid); end
        if (rvalid !== 1'b0)    begin errors++; $display("FAIL char_single_rvalid: got %b want 0", rvalid); end
        // A zero byte is still a character
        tx_ready = 1'b0;
        valid = 1'b1; wen = 1'b1; wdata = char_word(8'h00);
        tick();
        idle();
        checks += 2;
        if (tx_valid !== 1'b1)  begin errors++; $display("FAIL zero_char_valid: got %b want 1", tx_valid); end
        if (tx_data !== 8'h00)  begin errors++; $display("FAIL zero_char_data: got %h want 00", tx_data); end
        tx_ready = 1'b1;
        tick();
    endtask

    task automatic test_tx_full();
        logic [7:0] sent[17];
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            sent[i] = 8'($urandom);
            valid = 1'b1; wen = 1'b1; wdata = char_word(sent[i]);
            checks++;
            if (ready !== (i < 16)) begin errors++; $display("FAIL full_ready_%0d: got %b want %b", i, ready, (i < 16)); end
            tick();
            checks++;
            if (rvalid !== (i < 16)) begin errors++; $display("FAIL full_rvalid_%0d: got %b want %b", i, rvalid, (i < 16)); end
        end
        idle();
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        checks += 2;
        if (ready !== 1'b1)     begin errors++; $display("FAIL full_ready_after_pop: got %b want 1", ready); end
        if (tx_data !== sent[1]) begin errors++; $display("FAIL full_head_after_pop: got %h want %h", tx_data, sent[1]); end
        tx_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== sent[i]) begin
                errors++; $display("FAIL drain_%0d: got %b/%h want 1/%h", i, tx_valid, tx_data, sent[i]);
            end
            tick();
        end
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", tx_valid); end
    endtask

    task automatic test_rx();
        logic [7:0] b;
        do_reset();
        valid = 1'b1; wen = 1'b0;
        tick();
        checks += 2;
        if (rvalid !== 1'b1)  begin errors++; $display("FAIL rx_empty_rvalid: got %b want 1", rvalid); end
        if (rdata !== 64'd0)  begin errors++; $display("FAIL rx_empty_rdata: got %h want 0", rdata); end
        idle();
        rx_valid = 1'b1; rx_data = 8'h5A;
        tick();
        idle();
        valid = 1'b1; wen = 1'b0;
        tick();
        checks++;
        if (rdata !== 64'h5A) begin errors++; $display("FAIL rx_read_5a: got %h want 5a", rdata); end
        tick();
        checks++;
        if (rdata !== 64'd0)  begin errors++; $display("FAIL rx_read_after: got %h want 0", rdata); end
        // Byte arriving alongside a read of an empty FIFO is not visible yet
        b = 8'($urandom_range(1, 255));
        rx_valid = 1'b1; rx_data = b;
        tick();
        rx_valid = 1'b0;
        checks++;
        if (rdata !== 64'd0)  begin errors++; $display("FAIL rx_same_cycle: got %h want 0", rdata); end
        tick();
        checks++;
        if (rdata !== {56'b0, b}) begin errors++; $display("FAIL rx_next_read: got %h want %h", rdata, b); end
        idle();
    endtask

    task automatic test_rx_overflow();
        logic [7:0] exp_q[$];
        logic [7:0] b, got;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            if (i < 8) exp_q.push_back(b);
            rx_valid = 1'b1; rx_data = b;
            tick();
            checks++;
            if (rx_overflow !== (i == 8)) begin
                errors++; $display("FAIL ovf_after_%0d: got %b want %b", i, rx_overflow, (i == 8));
            end
        end
        idle();
        for (int i = 0; i < 9; i++) begin
            valid = 1'b1; wen = 1'b0;
            tick();
            got = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            checks++;
            if (rdata !== {56'b0, got}) begin errors++; $display("FAIL ovf_read_%0d: got %h want %h", i, rdata, got); end
        end
        idle();
        // Full FIFO with simultaneous pop and push: push accepted, no overflow
        do_reset();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            rx_valid = 1'b1; rx_data = b;
            tick();
        end
        b = 8'($urandom);
        exp_q.push_back(b);
        valid = 1'b1; wen = 1'b0; rx_valid = 1'b1; rx_data = b;
        tick();
        rx_valid = 1'b0;
        got = exp_q.pop_front();
        checks += 2;
        if (rx_overflow !== 1'b0)   begin errors++; $display("FAIL full_swap_ovf: got %b want 0", rx_overflow); end
        if (rdata !== {56'b0, got}) begin errors++; $display("FAIL full_swap_read: got %h want %h", rdata, got); end
        for (int i = 0; i < 8; i++) begin
            tick();
            got = exp_q.pop_front();
            checks++;
            if (rdata !== {56'b0, got}) begin errors++; $display("FAIL full_swap_order_%0d: got %h want %h", i, rdata, got); end
        end
        idle();
    endtask

    task automatic test_exit();
        do_reset();
        tx_ready = 1'b1;
        valid = 1'b1; wen = 1'b1; wdata = plain_word(1'b0);
        tick();
        wdata = char_word(8'h01);
        tick();
        checks += 2;
        if (done !== 1'b0)    begin errors++; $display("FAIL exit_other_done: got %b want 0", done); end
        if (tx_valid !== 1'b1) begin errors++; $display("FAIL exit_tagged_is_char: got %b want 1", tx_valid); end
        wdata = 64'h1;
        tick();
        checks += 3;
        if (done !== 1'b1 || success !== 1'b1) begin errors++; $display("FAIL exit_one: got %b/%b want 1/1", done, success); end
        if (exit_word !== 64'h1) begin errors++; $display("FAIL exit_one_word: got %h want 1", exit_word); end
        if (rvalid !== 1'b1)   begin errors++; $display("FAIL exit_rvalid: got %b want 1", rvalid); end
        wdata = 64'h3;
        tick();
        checks += 3;
        if (exit_word !== 64'h1) begin errors++; $display("FAIL exit_sticky_word: got %h want 1", exit_word); end
        if (success !== 1'b1)  begin errors++; $display("FAIL exit_sticky_success: got %b want 1", success); end
        if (rvalid !== 1'b1)   begin errors++; $display("FAIL exit_second_ack: got %b want 1", rvalid); end
        do_reset();
        valid = 1'b1; wen = 1'b1; wdata = 64'h3;
        tick();
        idle();
        checks += 2;
        if (done !== 1'b1 || success !== 1'b0) begin errors++; $display("FAIL exit_three: got %b/%b want 1/0", done, success); end
        if (exit_word !== 64'h3) begin errors++; $display("FAIL exit_three_word: got %h want 3", exit_word); end
    endtask

    task automatic test_random();
        int k;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            valid    = ($urandom_range(0, 3) != 0);
            wen      = $urandom_range(0, 1);
            k        = $urandom_range(0, 19);
            if (k < 12)      wdata = char_word(8'($urandom));
            else if (k < 18) wdata = plain_word(1'b0);
            else if (k < 19) wdata = plain_word(1'b1);
            else             wdata = 64'h1;
            addr     = $urandom;
            wmask    = 8'($urandom);
            tx_ready = ($urandom_range(0, 2) == 0);
            rx_valid = ($urandom_range(0, 2) == 0);
            rx_data  = 8'($urandom);
            tick();
            checks += 6;
            if (rvalid !== m_rvalid) begin errors++; $display("FAIL rnd_rvalid@%0d: got %b want %b", cyc, rvalid, m_rvalid); end
            if (tx_valid !== (tx_q.size() > 0)) begin
                errors++; $display("FAIL rnd_tx_valid@%0d: got %b want %b", cyc, tx_valid, (tx_q.size() > 0));
            end
            if (ready !== (tx_q.size() < TX_DEPTH)) begin
                errors++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, ready, (tx_q.size() < TX_DEPTH));
            end
            if (rx_overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf@%0d: got %b want %b", cyc, rx_overflow, m_ovf); end
            if (done !== m_done) begin errors++; $display("FAIL rnd_done@%0d: got %b want %b", cyc, done, m_done); end
            if (exit_word !== m_exit) begin errors++; $display("FAIL rnd_exit@%0d: got %h want %h", cyc, exit_word, m_exit); end
            if (tx_q.size() > 0) begin
                checks++;
                if (tx_data !== tx_q[0]) begin errors++; $display("FAIL rnd_tx_data@%0d: got %h want %h", cyc, tx_data, tx_q[0]); end
            end
            if (m_done) begin
                checks++;
                if (success !== m_success) begin errors++; $display("FAIL rnd_success@%0d: got %b want %b", cyc, success, m_success); end
            end
            if (m_rvalid && m_rd_resp) begin
                checks++;
                if (rdata !== m_rdata) begin errors++; $display("FAIL rnd_rdata@%0d: got %h want %h", cyc, rdata, m_rdata); end
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1; wen = 1'b1; wdata = char_word(8'($urandom));
            tick();
        end
        valid = 1'b1; wen = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks += 2;
        if (rvalid !== 1'b0)   begin errors++; $display("FAIL mid_rst_rvalid: got %b want 0", rvalid); end
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_tx_valid: got %b want 0", tx_valid); end
        // Request held through a reset edge must not produce a response
        @(negedge clk);
        @(negedge clk);
        idle();
        model_clear();
        rst = 1'b1;
        @(negedge clk);
        checks += 3;
        if (rvalid !== 1'b0)   begin errors++; $display("FAIL mid_rst_no_resp: got %b want 0", rvalid); end
        if (ready !== 1'b1)    begin errors++; $display("FAIL mid_rst_ready: got %b want 1", ready); end
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_empty: got %b want 0", tx_valid); end
    endtask

    initial begin
        rst = 1'b0;
        tx_ready = 1'b0;
        idle();
        model_clear();
        test_reset();
        test_char_write();
        test_tx_full();
        test_rx();
        test_rx_overflow();
        test_exit();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dbg_console.md
# dbg_console

Memory-mapped debug console responder on the MMIO debug port (`DBG_ADDR` region). It terminates the core's debug Membus traffic and buffers printf characters in a TX FIFO drained over a byte stream. Host input bytes are buffered in an RX FIFO and returned on core reads. Exit-flag writes are latched into a sticky done/result pair for the testbench or top level.

## Interface
Parameters:
- `DATA_WIDTH`, 64: Membus data width; equals `MEMBUS_DATA_WIDTH`.
- `TX_DEPTH`, 16: TX FIFO entries; power of two, ≥2.
- `RX_DEPTH`, 8: RX FIFO entries; power of two, ≥2.

Ports:
- Reset (already decided): one clock; reset is asynchronous and active-low.
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-low reset.
- `membus`  Membus slave  —  `valid`, `ready`, `addr`, `wen`, `wdata[63:0]`, `wmask[7:0]`, `rvalid`, `rdata[63:0]`.
- `tx_valid`  out  1  TX FIFO non-empty.
- `tx_data`  out  8  TX FIFO head byte.
- `tx_ready`  in  1  sink consumes the head when `tx_valid && tx_ready`.
- `rx_valid`  in  1  input byte strobe; no backpressure.
- `rx_data`  in  8  input byte.
- `rx_overflow`  out  1  sticky; set when an RX byte is dropped.
- `done`  out  1  sticky; exit flag written.
- `success`  out  1  valid when `done`; latched exit word equalled 1.
- `exit_word`  out  64  first exit word written.

## Operation
- Accept: a request is accepted on `valid && ready`. `ready = !tx_full`, computed only from FIFO state, never from the request.
- Response: every accepted request, read or write, produces exactly one `rvalid` pulse in the following cycle. `addr` and `wmask` are ignored; the whole region is one register.
- Char write: `wen` and `wdata[63:44]==20'h01010` push `wdata[7:0]` into the TX FIFO. A zero byte is also pushed.
- Exit write: `wen`, not a char, and `wdata[0]==1`. If `done` is 0: set `done`, `exit_word<=wdata`, `success<=(wdata==64'h1)`. If `done` is already 1: acknowledged, no state change.
- Other writes: acknowledged, no effect.
- Read: `rdata<={56'b0, rx_head}` and pop if the RX FIFO is non-empty, else `rdata<=0` (0 means no input). `rdata` is held between responses and is don't-care on write responses.
- RX push: on `rx_valid`. A byte arriving while the RX FIFO is full is dropped and sets `rx_overflow`.

## Timing
- Reset values: `rvalid=0`, `rdata=0`, `tx_valid=0`, `tx_data=0`, `rx_overflow=0`, `done=0`, `success=0`, `exit_word=0`. Both FIFOs are empty and `ready=1` once reset is released.
- Reset mid-operation clears the FIFOs and drops any pending `rvalid`. No response is issued for a request accepted in the reset cycle.
- Latency: response 1 cycle after accept. Throughput: one request per cycle.
- A pushed TX byte is visible on `tx_valid`/`tx_data` the next cycle.
- A pushed RX byte is readable by a read accepted the next cycle. A read accepted in the same cycle as `rx_valid` into an empty FIFO returns 0.
- TX simultaneous push/pop while non-full: count unchanged, order preserved. When full, no push can be accepted, but a pop frees space and `ready` rises the next cycle.
- RX full with simultaneous pop and `rx_valid`: the push is accepted, count is unchanged, no overflow.
- Pointers are `$clog2(DEPTH)+1` bits with the wrap bit; full/empty are derived from pointer compare, with no counter overflow.

## Structure
- Shared package: `DBG_PRINTF_TAG=20'h01010`, `DBG_EXIT_SUCCESS=64'h1`, `DBG_NO_INPUT=8'h00`.
- Sub-module `sync_fifo #(WIDTH, DEPTH)` is instantiated twice, for TX and RX. Its ports: push, pop, din, dout (head, registered-pointer read), empty, full.
- The top-level debug responder is replaced by an instance of this block. `test_success` is driven from `done && success`.

## Test plan
- Write `0x0101_0000_0000_0041` with `tx_ready=1` -> `rvalid` next cycle; `tx_valid` with `tx_data=0x41` the cycle after.
- Hold `tx_ready=0` and write 17 chars with `TX_DEPTH=16` -> 16 accepted, `ready=0`. Pulse `tx_ready` once -> `ready` rises next cycle; bytes drain in order.
- Read with RX empty -> `rdata=0`. Drive `rx_data=0x5A`, then read -> `rdata=0x5A`. Read again -> 0.
- Push 9 RX bytes with `RX_DEPTH=8` -> `rx_overflow=1`. Reads return the first 8 bytes in order.
- Write `64'h1` -> `done=1`, `success=1`. Then write `64'h3` -> `exit_word` stays 1. Separately, a first write of `64'h3` -> `done=1`, `success=0`, `exit_word=3`.
- Assert `rst` low with 5 TX bytes queued and a response pending -> `tx_valid=0` and `rvalid=0` immediately; `ready=1` after release.
